// File: rtl/aes_inv_key_sched_if.sv
// Key-request / round-key handshake bundle for the AES-128 inverse key schedule.
// master = consumer/controller side, slave = aes_inv_key_sched.
interface aes_inv_key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rkey_out;
    logic [3:0]   rkey_round;
    logic         rkey_valid;
    logic         rkey_ready;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rkey_ready,
        input  rkey_out, rkey_round, rkey_valid, busy, done
    );

    modport slave (
        input  start, key_in, rkey_ready,
        output rkey_out, rkey_round, rkey_valid, busy, done
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: emits round keys 10..0, two cycles per backward step.
// Define AES_INV_KEY_PRELOAD_EN to accept the cipher key and run the forward expansion first.
module aes_inv_key_sched (
    input  logic               i_clk,
    input  logic               i_rst_n,
    aes_inv_key_sched_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for start
    // EMIT   | round key presented, waiting for ready
    // SUB    | tmp <= g(w3) of the current key
    // UPD    | step key back one round
    // FSUB   | (preload) tmp <= g(w3) for a forward step
    // FUPD   | (preload) step key forward one round
    typedef enum logic [2:0] {
        S_IDLE, S_EMIT, S_SUB, S_UPD, S_FSUB, S_FUPD
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_rcon(input logic [3:0] i_idx);
        case (i_idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] f_g(input logic [31:0] i_w, input logic [3:0] i_idx);
        return {SBOX[i_w[23:16]] ^ f_rcon(i_idx), SBOX[i_w[15:8]],
                SBOX[i_w[7:0]], SBOX[i_w[31:24]]};
    endfunction

    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [31:0]  r_tmp, w_tmp_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic         r_done, w_done_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_tmp   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_tmp   <= w_tmp_nxt;
            r_round <= w_round_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_tmp_nxt   = r_tmp;
        w_round_nxt = r_round;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_key_nxt   = bus.key_in;
`ifdef AES_INV_KEY_PRELOAD_EN
                    w_round_nxt = 4'd0;
                    w_state_nxt = S_FSUB;
`else
                    w_round_nxt = 4'd10;
                    w_state_nxt = S_EMIT;
`endif
                end
            end
            S_EMIT: begin
                if (bus.rkey_ready) begin
                    if (r_round == 4'd0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_SUB;
                    end
                end
            end
            S_SUB: begin
                // w3 of the previous round is w7 ^ w6 of the current one
                w_tmp_nxt   = f_g(r_key[63:32] ^ r_key[31:0], r_round - 4'd1);
                w_state_nxt = S_UPD;
            end
            S_UPD: begin
                w_key_nxt   = {r_key[127:96] ^ r_tmp,
                               r_key[127:96] ^ r_key[95:64],
                               r_key[95:64]  ^ r_key[63:32],
                               r_key[63:32]  ^ r_key[31:0]};
                w_round_nxt = r_round - 4'd1;
                w_state_nxt = S_EMIT;
            end
`ifdef AES_INV_KEY_PRELOAD_EN
            S_FSUB: begin
                w_tmp_nxt   = f_g(r_key[31:0], r_round);
                w_state_nxt = S_FUPD;
            end
            S_FUPD: begin
                w_key_nxt   = {r_key[127:96] ^ r_tmp,
                               r_key[95:64] ^ r_key[127:96] ^ r_tmp,
                               r_key[63:32] ^ r_key[95:64] ^ r_key[127:96] ^ r_tmp,
                               r_key[31:0] ^ r_key[63:32] ^ r_key[95:64] ^ r_key[127:96] ^ r_tmp};
                w_round_nxt = r_round + 4'd1;
                w_state_nxt = (r_round == 4'd9) ? S_EMIT : S_FSUB;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.rkey_out   = r_key;
    assign bus.rkey_round = r_round;
    assign bus.rkey_valid = (r_state == S_EMIT);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: reference key expansion built from GF(2^8) arithmetic,
// random keys and random backpressure; follows AES_INV_KEY_PRELOAD_EN when defined.
module tb_aes_inv_key_sched;
`ifdef AES_INV_KEY_PRELOAD_EN
    localparam int OFS = 20;
`else
    localparam int OFS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_key_sched_if bus ();
    aes_inv_key_sched dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct { logic [3:0] rnd; logic [127:0] key; int lat; } exp_t;
    exp_t         sbq[$];
    exp_t         mon_e;
    int           n_vec = 0, n_bad = 0;
    int           cyc = 0, t0 = 0;
    int           ready_mode = 1;
    logic         exp_done = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] st_key;
    logic [3:0]   st_rnd;
    logic [7:0]   sbox [256];
    logic [31:0]  mw [44];
    logic [127:0] cap [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb_calc(input int a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int i);
        logic [7:0] rc = 8'h01;
        for (int k = 0; k < i; k++) rc = xt(rc);
        return rc;
    endfunction

    function automatic logic [31:0] g_tb(input logic [31:0] w, input int i);
        logic [31:0] r = {w[23:0], w[31:24]};
        return {sbox[r[31:24]] ^ rcon(i), sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
    endfunction

    // Full 44-word schedule; key_in fixes words 0..3 (cipher key) or 40..43 (round-10 key).
    function automatic void model(input logic [127:0] k);
`ifdef AES_INV_KEY_PRELOAD_EN
        for (int j = 0; j < 4; j++) mw[j] = k[127-32*j -: 32];
        for (int j = 4; j < 44; j++)
            mw[j] = mw[j-4] ^ ((j % 4 == 0) ? g_tb(mw[j-1], j/4 - 1) : mw[j-1]);
`else
        for (int j = 0; j < 4; j++) mw[40+j] = k[127-32*j -: 32];
        for (int j = 43; j >= 4; j--)
            mw[j-4] = mw[j] ^ ((j % 4 == 0) ? g_tb(mw[j-1], j/4 - 1) : mw[j-1]);
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic launch(input logic [127:0] k, input bit timed);
        model(k);
        bus.start  = 1'b1;
        bus.key_in = k;
        for (int r = 10; r >= 0; r--)
            sbq.push_back('{rnd: r[3:0], key: {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]},
                            lat: timed ? OFS + 1 + 3*(10-r) : -1});
        @(posedge clk); #1;
        t0 = cyc;
        bus.start  = 1'b0;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_seq(input logic [127:0] k, input bit timed);
        @(posedge clk); #1;
        launch(k, timed);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        chk("queue_drained", 128'(sbq.size()), 128'd0);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        bus.rkey_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.rkey_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if (bus.done !== exp_done) begin
                n_bad++;
                $display("FAIL done_pulse: got %b want %b (cyc %0d)", bus.done, exp_done, cyc);
            end
            exp_done = 1'b0;
            if (prev_stall && bus.rkey_valid) begin
                n_vec++;
                if (bus.rkey_out !== st_key || bus.rkey_round !== st_rnd) begin
                    n_bad++;
                    $display("FAIL stall_hold: got %h/%0d want %h/%0d",
                             bus.rkey_out, bus.rkey_round, st_key, st_rnd);
                end
            end
            prev_stall = bus.rkey_valid && !bus.rkey_ready;
            st_key     = bus.rkey_out;
            st_rnd     = bus.rkey_round;
            if (bus.rkey_valid && bus.rkey_ready) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_key: got %h round %0d", bus.rkey_out, bus.rkey_round);
                end else begin
                    mon_e = sbq.pop_front();
                    if (bus.rkey_out !== mon_e.key || bus.rkey_round !== mon_e.rnd) begin
                        n_bad++;
                        $display("FAIL round_key: got %h/%0d want %h/%0d",
                                 bus.rkey_out, bus.rkey_round, mon_e.key, mon_e.rnd);
                    end
                    if (mon_e.lat >= 0) begin
                        n_vec++;
                        if (cyc - t0 + 1 != mon_e.lat) begin
                            n_bad++;
                            $display("FAIL key_latency: round %0d got T+%0d want T+%0d",
                                     mon_e.rnd, cyc - t0 + 1, mon_e.lat);
                        end
                    end
                    cap[mon_e.rnd] = bus.rkey_out;
                    if (mon_e.rnd == 4'd0) exp_done = 1'b1;
                end
            end
        end else begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic [127:0] kat, rk;
        int n;
        bus.start  = 1'b0;
        bus.key_in = '0;
        for (int a = 0; a < 256; a++) sbox[a] = sb_calc(a);
`ifdef AES_INV_KEY_PRELOAD_EN
        kat = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
        kat = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

        #23;
        chk("rst_rkey_out",   bus.rkey_out, 128'd0);
        chk("rst_rkey_round", 128'(bus.rkey_round), 128'd0);
        chk("rst_rkey_valid", 128'(bus.rkey_valid), 128'd0);
        chk("rst_busy",       128'(bus.busy), 128'd0);
        chk("rst_done",       128'(bus.done), 128'd0);
        rst_n = 1'b1;

        // Known-answer sequence, ready held high
        ready_mode = 1;
        run_seq(kat, 1'b1);
        wait_done(200);
        chk("busy_after_done", 128'(bus.busy), 128'd0);
        chk("kat_round10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("kat_round9",  cap[9],  128'hac7766f319fadc2128d12941575c006e);
        chk("kat_round1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("kat_round0",  cap[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Same key under random backpressure
        ready_mode = 2;
        run_seq(kat, 1'b0);
        wait_done(2000);
        chk("bp_round10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("bp_round0",  cap[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

        // start while busy must be ignored
        run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.start = 1'b1;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(2000);

        // Asynchronous reset while round 5 is presented, then a clean rerun
        ready_mode = 1;
        rk = {$urandom, $urandom, $urandom, $urandom};
        run_seq(rk, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.rkey_valid && bus.rkey_round == 4'd5) && n < 300);
        chk("reach_round5", 128'(bus.rkey_valid && bus.rkey_round == 4'd5), 128'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rkey_out",   bus.rkey_out, 128'd0);
        chk("arst_rkey_round", 128'(bus.rkey_round), 128'd0);
        chk("arst_rkey_valid", 128'(bus.rkey_valid), 128'd0);
        chk("arst_busy",       128'(bus.busy), 128'd0);
        sbq.delete();
        repeat (3) @(posedge clk);
        chk("arst_no_done", 128'(bus.done), 128'd0);
        #3 rst_n = 1'b1;
        run_seq(rk, 1'b1);
        wait_done(200);

        // All-zero key, then a back-to-back start during the done cycle
        run_seq(128'd0, 1'b1);
        wait_done(200);
        launch({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        wait_done(200);

        for (int s = 0; s < 4; s++) begin
            ready_mode = (s % 2 == 0) ? 2 : 1;
            run_seq({$urandom, $urandom, $urandom, $urandom}, ready_mode == 1);
            wait_done(2000);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative AES-128 inverse key schedule for the decryption datapath. Takes the round-10 key and steps the expansion backwards, presenting round keys 10, 9, …, 0 on a valid/ready output port, one key per step. It is the counterpart of the forward round-key generator: the decrypt round engine consumes keys in reverse order without storing all eleven. One S-box lookup path is registered, so each backward step costs two internal cycles.

## Interface
- No parameters; AES-128 only (10 rounds, Rcon = 01,02,04,08,10,20,40,80,1b,36 for indices 0..9).
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  load key_in and begin a sequence; sampled only in IDLE
- key_in  in  128  round-10 key; [127:96] = w0, [31:0] = w3; byte [127:120] is byte 0
- rkey_out  out  128  current round key
- rkey_round  out  4  round index of rkey_out (10 down to 0)
- rkey_valid  out  1  rkey_out/rkey_round valid
- rkey_ready  in  1  consumer accepts key when rkey_valid & rkey_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after round-0 key accepted

## Operation
- Registers: key[127:0], tmp[31:0], round[3:0], state.
- g(w) = SubWord(RotWord(w)) ^ {Rcon[i], 24'h0}; RotWord takes bytes [23:16],[15:8],[7:0],[31:24].
- States:
  - IDLE: start=1 → key<=key_in, round<=10 → EMIT. start=0 → stay.
  - EMIT: rkey_valid=1. On handshake: round==0 → IDLE, done pulse next cycle; else → SUB.
  - SUB: tmp <= g(key[63:32]^key[31:0]) with i = round-1 → UPD.
  - UPD: key <= {key[127:96]^tmp, key[127:96]^key[95:64], key[95:64]^key[63:32], key[63:32]^key[31:0]}; round <= round-1 → EMIT.
- rkey_out = key and rkey_round = round at all times; stable while rkey_valid & !rkey_ready.
- start outside IDLE ignored; key_in sampled only in the IDLE→load cycle.
- rkey_ready outside EMIT ignored.
- Rcon index range is 0..9 only; round never decrements below 0.

## Timing
- Reset values: key=0, tmp=0, round=0, state=IDLE; rkey_out=0, rkey_round=0, rkey_valid=0, busy=0, done=0.
- rst asserted mid-sequence: immediate return to reset values; no done pulse; sequence discarded.
- start accepted at edge T → rkey_valid high from T+1 with round 10.
- With rkey_ready held high: one key per 3 cycles; round r valid at T+1+3·(10−r); round 0 at T+31; done high T+32 only; busy low from T+32.
- rkey_ready low stalls in EMIT indefinitely, no state change.
- start high in the done cycle: accepted (state is IDLE), next sequence starts.

## Configuration
- AES_INV_KEY_PRELOAD_EN defined: key_in is the cipher key (round 0). After start, module first runs 10 forward steps (states FSUB/FUPD, 2 cycles each, tmp <= g(key[31:0]) with i = 0..9, key words updated as forward AES), rkey_valid low, busy high; then enters EMIT with round 10. First valid at T+21; round 0 at T+51; done at T+52.
- Not defined: key_in is the round-10 key; no forward states; timing as above.

## Test plan
- FIPS-197 A.1: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1 → round10 = d014f9a8…0ca6 at T+1, round9 = ac7766f319fadc2128d12941575c006e at T+4, round1 = a0fafe1788542cb123a339392a6c7605, round0 = 2b7e151628aed2a6abf7158809cf4f3c at T+31, done at T+32 only.
- Backpressure: same key, rkey_ready randomly low 50% → identical 11-key sequence, rkey_out/rkey_round unchanged during every stall.
- start pulsed while busy with a different key_in → ignored; sequence unaffected.
- rst low during round 5 EMIT → all outputs 0 asynchronously, no done; fresh start then yields full correct sequence.
- All-zero key_in → round0 equals the cipher key whose forward expansion gives zero round-10 key; back-to-back start in done cycle accepted with first valid next cycle.
- AES_INV_KEY_PRELOAD_EN: key_in = 2b7e151628aed2a6abf7158809cf4f3c → no valid until T+21, then round10 = d014f9a8c9ee2589e13f0cc8b6630ca6, round0 at T+51, done at T+52.
